armleocpu_reg_file: RTL and testbench
=====================================

// Module: armleocpu_reg_file
//
// PURPOSE
//   RV32I integer register file: 32 x 32-bit registers, x0 hardwired to zero.
//   Two combinational read ports (rs1, rs2), one synchronous write port (rd).
//   Sits in the CPU decode/execute path; operands are read in the same cycle
//   the address is presented, and writeback commits on the next rising edge.
//
// PARAMETERS
//   None. Widths are fixed: XLEN=32, 32 registers, 5-bit addresses.
//
// PORTS
//   clk          input   1   single clock; all writes on rising edge
//   async_rst_n  input   1   reset, asynchronous, active-low
//   rs1_addr     input   5   read port 1 register index
//   rs1_rdata    output  32  read port 1 data (combinational)
//   rs2_addr     input   5   read port 2 register index
//   rs2_rdata    output  32  read port 2 data (combinational)
//   rd_addr      input   5   write register index
//   rd_data      input   32  write data
//   rd_write     input   1   write enable
//
// BEHAVIOUR
//   - Storage: registers x1..x31, 32 bits each. x0 has no storage.
//   - Reset: async_rst_n low immediately clears x1..x31 to 32'h0, independent
//     of clk. Reads during and after reset return 0 until written.
//   - Write: on posedge clk with rd_write=1 and rd_addr!=0, reg[rd_addr] <=
//     rd_data. Writes with rd_addr==0 are discarded. rd_write=0: no change.
//   - Read: rsN_rdata = (rsN_addr==0) ? 0 : reg[rsN_addr], purely
//     combinational, zero-cycle latency. Output follows address changes and
//     register updates within the same cycle.
//   - No write-to-read bypass: a read of the register being written in the
//     same cycle returns the OLD value; the new value is visible only after
//     the rising edge that commits the write.
//   - Both read ports are independent; same address on both returns the same
//     data. Read and write of different registers in one cycle don't interact.
//   - Reset asserted concurrently with a write edge: reset wins; register = 0.
//   - X/unknown addresses need not be handled; all 5-bit values are legal.
//   - rsN_rdata must never be X for x0 or after reset.
//
// STRUCTURE
//   - Shared package (armleocpu_defines): XLEN=32, REG_COUNT=32,
//     REG_ADDR_W=5 constants; register index type.
//   - Single module; no sub-module. Flop array x1..x31 with async-clear, two
//     32:1 read muxes with x0 forced to zero. No memory macro inference
//     (async reset clear required).
//
// TESTING
//   1. Reset: pulse async_rst_n low with clk idle; read all 32 addresses on
//      both ports -> every rs1_rdata/rs2_rdata == 32'h0.
//   2. x0 write: rd_write=1, rd_addr=0, rd_data=32'hFF00FF00, one edge;
//      rs1_addr=0 -> rs1_rdata == 0.
//   3. No bypass: rd_write=1, rd_addr=1, rd_data=32'hFF00FF00, rs2_addr=1
//      before the edge -> rs2_rdata == 0; after the edge, rs1_addr=rs2_addr=1
//      -> both == 32'hFF00FF00.
//   4. Write enable off: rd_write=0, rd_addr=2, rd_data=32'h12345678, edge
//      -> x2 reads 0.
//   5. Full sweep: write x1..x31 with value 32'hA5A50000|index, read back on
//      both ports with different addresses per cycle -> exact values; x0 == 0.
//   6. Reset mid-operation: after step 5, assert async_rst_n low between
//      edges -> all reads return 0 immediately, without a clock edge.

Source files
------------

// File: rtl/armleocpu_defines_pkg.sv
// Shared RV32I integer register file constants and types.
package armleocpu_defines;

    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/armleocpu_reg_file.sv
// RV32I integer register file: x1..x31 as async-cleared flops, x0 reads as zero.
// Two combinational read ports, one write port committed on the rising edge.
module armleocpu_reg_file
    import armleocpu_defines::*;
(
    input  logic                  clk,
    input  logic                  async_rst_n,

    input  logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [XLEN-1:0]       rs1_rdata,

    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs2_rdata,

    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]       rd_data,
    input  logic                  rd_write
);

    // Flat view for the read muxes; entry 0 is a constant, not storage.
    xlen_t read_view [REG_COUNT];

    assign read_view[0] = '0;

    for (genvar g = 1; g < REG_COUNT; g++) begin : g_reg
        xlen_t reg_q;
        xlen_t reg_d;
        logic  wr_en;

        assign wr_en = rd_write && (rd_addr == reg_idx_t'(g));
        assign reg_d = wr_en ? rd_data : reg_q;

        always_ff @(posedge clk or negedge async_rst_n) begin
            if (!async_rst_n) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign read_view[g] = reg_q;
    end

    // No write bypass: a read of the register being written returns the old value.
    always_comb begin
        rs1_rdata = read_view[rs1_addr];
        rs2_rdata = read_view[rs2_addr];
    end

endmodule

// File: tb/tb_armleocpu_reg_file.sv
// Directed plus randomized bench for armleocpu_reg_file with a reference model and expected queue.
module tb_armleocpu_reg_file;

    logic        clk;
    logic        clk_en;
    logic        async_rst_n;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_rdata;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_write;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    int          tests;
    int          failures;

    armleocpu_reg_file dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .rs1_addr    (rs1_addr),
        .rs1_rdata   (rs1_rdata),
        .rs2_addr    (rs2_addr),
        .rs2_rdata   (rs2_rdata),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_write    (rd_write)
    );

    // Clock can be parked low so reset behaviour is observed without edges.
    always #5 clk = clk_en ? ~clk : clk;

    task automatic compare(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        rs1_addr = a1;
        rs2_addr = a2;
        exp_q.push_back(model[a1]);
        exp_q.push_back(model[a2]);
        #1;
        compare($sformatf("%s rs1 x%0d", tag, a1), rs1_rdata);
        compare($sformatf("%s rs2 x%0d", tag, a2), rs2_rdata);
    endtask

    // One rising edge; the model commits the write the DUT should take.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_write && rd_addr != 5'd0) model[rd_addr] = rd_data;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    initial begin
        tests       = 0;
        failures    = 0;
        clk         = 1'b0;
        clk_en      = 1'b0;
        async_rst_n = 1'b1;
        rs1_addr    = 5'd0;
        rs2_addr    = 5'd0;
        rd_addr     = 5'd0;
        rd_data     = 32'h0;
        rd_write    = 1'b0;
        clear_model();

        // Reset pulse with the clock idle; reads are zero during and after.
        #3 async_rst_n = 1'b0;
        #2;
        check_pair("rst_low", 5'd3, 5'd17);
        check_pair("rst_low", 5'd31, 5'd1);
        #2 async_rst_n = 1'b1;
        for (int i = 0; i < 32; i++) check_pair("reset", 5'(i), 5'(31 - i));

        clk_en = 1'b1;
        @(negedge clk);

        // Writes to x0 are discarded.
        rd_write = 1'b1;
        rd_addr  = 5'd0;
        rd_data  = 32'hFF00FF00;
        tick();
        check_pair("x0_write", 5'd0, 5'd0);

        // No bypass: old value before the edge, new value after.
        rd_addr = 5'd1;
        check_pair("pre_edge", 5'd0, 5'd1);
        tick();
        rd_write = 1'b0;
        check_pair("post_edge", 5'd1, 5'd1);

        // Write enable off leaves the target untouched.
        rd_addr = 5'd2;
        rd_data = 32'h12345678;
        tick();
        check_pair("we_off", 5'd2, 5'd2);

        // Full sweep of x1..x31.
        rd_write = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rd_addr = 5'(i);
            rd_data = 32'hA5A50000 | 32'(i);
            tick();
        end
        rd_write = 1'b0;
        for (int i = 0; i < 32; i++) check_pair("sweep", 5'(i), 5'((i + 7) % 32));

        // Random writes with concurrent reads of arbitrary registers.
        for (int n = 0; n < 60; n++) begin
            rd_write = 1'($urandom_range(0, 1));
            rd_addr  = 5'($urandom_range(0, 31));
            rd_data  = $urandom;
            check_pair("rand_pre", 5'($urandom_range(0, 31)), rd_addr);
            tick();
            check_pair("rand_post", rd_addr, 5'($urandom_range(0, 31)));
        end
        rd_write = 1'b0;

        // Reset between edges with the clock parked: immediate clear.
        @(negedge clk);
        clk_en = 1'b0;
        #2 async_rst_n = 1'b0;
        clear_model();
        for (int i = 0; i < 32; i++) check_pair("mid_reset", 5'(i), 5'(31 - i));
        async_rst_n = 1'b1;
        #1;
        check_pair("after_reset", 5'd10, 5'd20);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
